vga_frame_reader: RTL



---
 rtl/vga_frame_reader.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_reader.sv
// vga_frame_reader: VGA timing generator (640x480@60 by default) that streams a
// byte-per-pixel frame buffer out in raster order through a synchronous-read RAM
// port. It drives 4-bit grayscale or colour bars, with sync and blanking delayed so
// that they stay cycle-aligned with the pixel data at the pins.
module vga_frame_reader #(
   parameter int RD_LAT    = 1,    // frame-buffer read latency, legal 1..3
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        test_pattern,
   input  logic [7:0]  rd_data,
   output logic [18:0] rd_addr,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int BAR_W   = H_VISIBLE / 8;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_BEG   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [9:0] VS_BEG   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
   localparam logic [9:0] BAR_LAST = 10'(BAR_W - 1);

   // Per-pixel control that travels alongside the RAM read.
   typedef struct packed {
      logic       active;
      logic       hs;
      logic       vs;
      logic       fs;
      logic [2:0] bar;
   } pix_info_t;

   localparam pix_info_t BLANK_INFO = '{active: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, bar: 3'd0};

   // Colour-bar palette, left to right.
   function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    return 12'hFFF;
         3'd1:    return 12'hFF0;
         3'd2:    return 12'h0FF;
         3'd3:    return 12'h0F0;
         3'd4:    return 12'hF0F;
         3'd5:    return 12'hF00;
         3'd6:    return 12'h00F;
         default: return 12'h000;
      endcase
   endfunction

   logic [9:0]  h_q, h_d;
   logic [9:0]  v_q, v_d;
   logic [9:0]  bar_px_q, bar_px_d;
   logic [2:0]  bar_idx_q, bar_idx_d;
   logic [18:0] a_q, a_d;
   logic        pat_q, pat_d;
   logic [18:0] rd_addr_q, rd_addr_d;
   pix_info_t   info_c;
   pix_info_t   pipe_q [RD_LAT+1];
   pix_info_t   pipe_d [RD_LAT+1];
   logic [11:0] rgb_q, rgb_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        fs_q, fs_d;

   // Only the upper nibble of each byte reaches the 4-bit DAC.
   logic unused_rd_lsbs;
   assign unused_rd_lsbs = ^rd_data[3:0];

   // Counter stage: raster position, bar tracking, next-pixel address, frame source.
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path infers a latch.
      h_d       = h_q + 10'd1;
      v_d       = v_q;
      bar_px_d  = bar_px_q + 10'd1;
      bar_idx_d = bar_idx_q;
      if (h_q == H_LAST) begin
         h_d       = '0;
         bar_px_d  = '0;
         bar_idx_d = '0;
         v_d       = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end else if (bar_px_q == BAR_LAST) begin
         bar_px_d  = '0;
         bar_idx_d = bar_idx_q + 3'd1;
      end

      info_c.active = (h_q < H_VIS) && (v_q < V_VIS);
      info_c.hs     = !((h_q >= HS_BEG) && (h_q < HS_END));
      info_c.vs     = !((v_q >= VS_BEG) && (v_q < VS_END));
      info_c.fs     = (h_q == 10'd0) && (v_q == 10'd0);
      info_c.bar    = bar_idx_q;

      // The address advances only on visible pixels, so during blanking it already
      // points at the next visible pixel; it wraps to 0 after the last one.
      a_d = a_q;
      if (info_c.active) begin
         a_d = ((h_q == H_VIS - 10'd1) && (v_q == V_VIS - 10'd1)) ? 19'd0 : a_q + 19'd1;
      end

      pat_d     = info_c.fs ? test_pattern : pat_q;
      rd_addr_d = a_q;
   end

   // Control shift register: stage 0 pairs with rd_addr, the rest cover the RAM latency.
   always_comb begin
      pipe_d[0] = info_c;
      for (int k = 1; k <= RD_LAT; k++) begin
         pipe_d[k] = pipe_q[k-1];
      end
   end

   // Output stage: pick the video source and force black outside the visible area.
   always_comb begin
      rgb_d = 12'h000;
      if (pipe_q[RD_LAT].active) begin
         rgb_d = pat_q ? bar_rgb(pipe_q[RD_LAT].bar) : {3{rd_data[7:4]}};
      end
      hs_d = pipe_q[RD_LAT].hs;
      vs_d = pipe_q[RD_LAT].vs;
      fs_d = pipe_q[RD_LAT].fs;
   end

   // State registers with synchronous reset back to (0,0) and blank outputs.
   always_ff @(posedge pclk) begin
      if (rst) begin
         h_q       <= '0;
         v_q       <= '0;
         bar_px_q  <= '0;
         bar_idx_q <= '0;
         a_q       <= '0;
         pat_q     <= 1'b0;
         rd_addr_q <= '0;
         // NOTE: the pipeline is a few flops rather than a RAM, so every stage is
         // reset; otherwise stale sync levels would reach the pins after reset.
         for (int k = 0; k <= RD_LAT; k++) begin
            pipe_q[k] <= BLANK_INFO;
         end
         rgb_q <= 12'h000;
         hs_q  <= 1'b1;
         vs_q  <= 1'b1;
         fs_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register sample pre-edge values,
         // which is what keeps the stages of the pipeline one cycle apart.
         h_q       <= h_d;
         v_q       <= v_d;
         bar_px_q  <= bar_px_d;
         bar_idx_q <= bar_idx_d;
         a_q       <= a_d;
         pat_q     <= pat_d;
         rd_addr_q <= rd_addr_d;
         for (int k = 0; k <= RD_LAT; k++) begin
            pipe_q[k] <= pipe_d[k];
         end
         rgb_q <= rgb_d;
         hs_q  <= hs_d;
         vs_q  <= vs_d;
         fs_q  <= fs_d;
      end
   end

   assign rd_addr     = rd_addr_q;
   assign vga_r       = rgb_q[11:8];
   assign vga_g       = rgb_q[7:4];
   assign vga_b       = rgb_q[3:0];
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign frame_start = fs_q;

endmodule
